// File: rtl/mux_2x1_rr_burst_arbiter_if.sv
// mux_2x1_rr_burst_arbiter_if: requester/downstream handshake and mux control bundle for the burst arbiter
interface mux_2x1_rr_burst_arbiter_if #(parameter int CNT_WIDTH = 5);
  logic [1:0] i_req;
  logic [1:0] i_last;
  logic i_ready;
  logic [1:0] o_grant;
  logic [1:0] o_mux_valid;
  logic o_mux_en;
  logic o_owner;
  logic o_busy;
  logic [CNT_WIDTH-1:0] o_beat_cnt;
  logic o_trunc;
  modport master (output i_req, i_last, i_ready,
                  input o_grant, o_mux_valid, o_mux_en, o_owner, o_busy, o_beat_cnt, o_trunc);
  modport slave (input i_req, i_last, i_ready,
                 output o_grant, o_mux_valid, o_mux_en, o_owner, o_busy, o_beat_cnt, o_trunc);
endinterface

// File: rtl/mux_2x1_rr_burst_arbiter.sv
// mux_2x1_rr_burst_arbiter: round-robin whole-burst arbiter driving a shared 2:1 mux
module mux_2x1_rr_burst_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CNT_WIDTH = 5
) (
  input logic clk,
  input logic rst,
  mux_2x1_rr_burst_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state_q, state_d;
  logic rr_q, rr_d, owner_q, owner_d, trunc_q, trunc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic own, k, xfer, rel, nxt;
  always_comb begin
    own = state_q != IDLE;
    k = state_q == OWN1;
    xfer = own & ~rst & bus.i_req[k] & bus.i_ready;
    rel = xfer & (bus.i_last[k] | (cnt_q == CNT_WIDTH'(MAX_BURST - 1)));
    nxt = (bus.i_req == 2'b11) ? rr_q : bus.i_req[1];
    state_d = state_q;
    rr_d = rr_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    trunc_d = 1'b0;
    if (!own && bus.i_req != 2'b00) begin
      state_d = nxt ? OWN1 : OWN0;
      owner_d = nxt;
      cnt_d = '0;
    end else if (rel) begin
      // hand straight to the other requester when it is waiting, no idle bubble
      rr_d = ~k;
      cnt_d = '0;
      trunc_d = ~bus.i_last[k];
      state_d = bus.i_req[~k] ? (k ? OWN0 : OWN1) : IDLE;
      owner_d = bus.i_req[~k] ? ~k : k;
    end else if (xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      owner_q <= 1'b0;
      trunc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      owner_q <= owner_d;
      trunc_q <= trunc_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.o_grant = (own & ~rst & bus.i_ready) ? {k, ~k} : 2'b00;
  assign bus.o_mux_valid = xfer ? {k, ~k} : 2'b00;
  assign bus.o_mux_en = ~rst;
  assign bus.o_owner = ~rst & owner_q;
  assign bus.o_busy = ~rst & own;
  assign bus.o_beat_cnt = rst ? '0 : cnt_q;
  assign bus.o_trunc = ~rst & trunc_q;
endmodule

// File: tb/tb_mux_2x1_rr_burst_arbiter.sv
// tb_mux_2x1_rr_burst_arbiter: randomized bench checked against a burst-level reference model
module tb_mux_2x1_rr_burst_arbiter;
  localparam int MAX_BURST = 16;
  localparam int CNT_WIDTH = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mux_2x1_rr_burst_arbiter_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();
  mux_2x1_rr_burst_arbiter #(.MAX_BURST(MAX_BURST), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0;
  int own_m = -1, rr_m = 0, cnt_m = 0, trunc_m = 0, last_own_m = 0;
  int len [2] = '{0, 0};
  int rdy_pct = 100, drop_pct = 0, n_trunc = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input bit r);
    logic [1:0] req, last;
    logic rdy;
    bit x;
    int o;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      req[i] = len[i] > 0 && $urandom_range(99) >= drop_pct;
      last[i] = req[i] ? (len[i] == 1) : 1'($urandom);
    end
    rdy = $urandom_range(99) < rdy_pct;
    rst = r;
    bus.i_req = req;
    bus.i_last = last;
    bus.i_ready = rdy;
    #1;
    x = !r && own_m >= 0 && req[own_m] && rdy;
    chk("grant", bus.o_grant, (!r && own_m >= 0 && rdy) ? 2'(1 << own_m) : 2'b00);
    chk("mux_valid", bus.o_mux_valid, x ? 2'(1 << own_m) : 2'b00);
    chk("onehot", $countones(bus.o_mux_valid) <= 1, 1);
    chk("mux_en", bus.o_mux_en, !r);
    chk("busy", bus.o_busy, !r && own_m >= 0);
    chk("owner", bus.o_owner, r ? 0 : last_own_m);
    chk("beat_cnt", bus.o_beat_cnt, r ? 0 : cnt_m);
    chk("trunc", bus.o_trunc, r ? 0 : trunc_m);
    if (bus.o_trunc) n_trunc++;
    if (r) begin
      own_m = -1; rr_m = 0; cnt_m = 0; trunc_m = 0; last_own_m = 0;
    end else begin
      trunc_m = 0;
      if (own_m < 0) begin
        if (req != 0) begin
          o = (req == 2'b11) ? rr_m : int'(req[1]);
          own_m = o; last_own_m = o; cnt_m = 0;
        end
      end else if (x) begin
        len[own_m]--;
        if (last[own_m] || cnt_m + 1 == MAX_BURST) begin
          trunc_m = !last[own_m];
          rr_m = 1 - own_m;
          cnt_m = 0;
          o = 1 - own_m;
          own_m = req[o] ? o : -1;
          if (own_m >= 0) last_own_m = own_m;
        end else cnt_m++;
      end
    end
  endtask
  task automatic drain(input int bound);
    int n = 0;
    while ((len[0] > 0 || len[1] > 0) && n < bound) begin
      cyc(0);
      n++;
    end
    chk("drain", len[0] + len[1], 0);
    cyc(0);
  endtask
  initial begin
    bus.i_req = 0; bus.i_last = 0; bus.i_ready = 0;
    cyc(1); cyc(1);
    len = '{3, 0}; drain(20);
    len = '{2, 2}; drain(20);
    len = '{2, 2}; drain(20);
    rdy_pct = 40; len = '{0, 8}; drain(100);
    rdy_pct = 100; n_trunc = 0; len = '{20, 3}; drain(60);
    chk("trunc_pulses", n_trunc, 1);
    len = '{10, 0};
    repeat (6) cyc(0);
    cyc(1);
    len = '{0, 0};
    cyc(0); cyc(0);
    len = '{MAX_BURST, 0}; drain(40);
    len = '{1, 1}; drain(20);
    for (int t = 0; t < 40; t++) begin
      rdy_pct = $urandom_range(30, 100);
      drop_pct = $urandom_range(0, 30);
      len[0] = $urandom_range(0, 22);
      len[1] = $urandom_range(1, 22);
      drain(600);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
